// File: rtl/xm23_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xm23_pkg
//  Description : Shared types and constants for the XM23 instruction path.
//                word_t / addr_t are the 16-bit instruction word and byte
//                address; fetch_entry_t pairs a fetched word with its PC.
//  Revision    : 1.0  initial release
// ============================================================================
package xm23_pkg;

   typedef logic [15:0] word_t;
   typedef logic [15:0] addr_t;

   // Byte distance between consecutive instructions.
   localparam addr_t INST_BYTES = 16'd2;

   typedef struct packed {
      word_t inst;
      addr_t pc;
   } fetch_entry_t;

endpackage : xm23_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Two-entry instruction FIFO of fetch_entry_t. The head always
//                lives in slot 0, so head outputs are plain register reads.
//  Ports       : clock, reset        - clock, synchronous active-high reset
//                clear_i             - drop all entries (synchronous)
//                push_i, push_*_i    - append {inst, pc} at the tail
//                pop_i               - remove the head
//                head_*_o            - head entry contents
//                count_o             - number of valid entries (0..2)
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_queue
   import xm23_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        push_i,
   input  logic [15:0] push_inst_i,
   input  logic [15:0] push_pc_i,
   input  logic        pop_i,
   output logic [15:0] head_inst_o,
   output logic [15:0] head_pc_o,
   output logic [1:0]  count_o
);

   fetch_entry_t entry0_q, entry0_d;
   fetch_entry_t entry1_q, entry1_d;
   logic [1:0]   count_q, count_d;

   logic         w_pop;
   logic         w_push;
   logic [1:0]   w_slot;
   fetch_entry_t w_new;

   // Guard against popping empty or pushing full; the producer's issue
   // rule already guarantees neither happens.
   assign w_pop  = pop_i && (count_q != 2'd0);
   assign w_push = push_i && ((count_q != 2'd2) || w_pop);
   // Tail slot after this cycle's pop has shifted the queue forward.
   assign w_slot = count_q - {1'b0, w_pop};
   assign w_new  = '{inst: push_inst_i, pc: push_pc_i};

   always_comb begin
      entry0_d = entry0_q;
      entry1_d = entry1_q;
      count_d  = count_q;
      if (clear_i) begin
         count_d = 2'd0;
      end else begin
         if (w_pop) begin
            entry0_d = entry1_q;
         end
         if (w_push) begin
            if (w_slot == 2'd0) begin
               entry0_d = w_new;
            end else begin
               entry1_d = w_new;
            end
         end
         count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         entry0_q <= '0;
         entry1_q <= '0;
         count_q  <= 2'd0;
      end else begin
         entry0_q <= entry0_d;
         entry1_q <= entry1_d;
         count_q  <= count_d;
      end
   end

   assign head_inst_o = entry0_q.inst;
   assign head_pc_o   = entry0_q.pc;
   assign count_o     = count_q;

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : XM23 instruction fetch. Holds the PC, issues one read per
//                cycle to a 1-cycle-latency instruction memory whenever the
//                queue plus the outstanding read leave room, and hands words
//                to decode over a valid/ready handshake. redirect flushes the
//                queue, drops any returning word and reloads the PC.
//  Ports       : clock, reset            - clock, synchronous active-high reset
//                imem_addr/imem_rd       - read request (addr bit 0 always 0)
//                imem_data               - read data, one cycle after imem_rd
//                redirect/redirect_pc    - flush and new fetch address
//                inst/inst_pc/inst_valid - queue head towards decode
//                inst_ready              - decode accepts the head
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage
   import xm23_pkg::*;
#(
   parameter addr_t RESET_PC  = 16'h0000,
   parameter int    BUF_DEPTH = 2          // only 2 is supported
)
(
   input  logic        clock,
   input  logic        reset,
   output logic [15:0] imem_addr,
   output logic        imem_rd,
   input  logic [15:0] imem_data,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [15:0] inst,
   output logic [15:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready
);

   localparam addr_t      c_PC_MASK  = 16'hFFFE;
   localparam addr_t      c_RESET_PC = RESET_PC & c_PC_MASK;
   localparam logic [1:0] c_DEPTH    = BUF_DEPTH[1:0];

   addr_t      pc_q, pc_d;
   logic       inflight_q, inflight_d;
   addr_t      inflight_pc_q, inflight_pc_d;
   // Squashes a late return after a redirect. With a 1-cycle memory the
   // redirect cycle itself drops the return, so this never becomes 1; it is
   // kept so a deeper memory only needs the set condition added.
   logic       squash_q, squash_d;

   logic [1:0] w_count;
   logic [1:0] w_occupancy;
   logic       w_pop;
   logic       w_push;
   logic       w_issue;

   assign inst_valid  = (w_count != 2'd0);
   assign w_pop       = inst_valid & inst_ready;
   // Queued words plus the word still in the memory pipe.
   assign w_occupancy = w_count + {1'b0, inflight_q};
   // A pop this cycle frees a slot for the word that returns next cycle,
   // so a full stage may still issue and no bubble appears.
   assign w_issue     = !reset && !redirect &&
                        ((w_occupancy < c_DEPTH) ||
                         ((w_occupancy == c_DEPTH) && w_pop));
   assign w_push      = inflight_q && !squash_q && !redirect;

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      squash_d      = squash_q;
      if (redirect) begin
         pc_d     = redirect_pc & c_PC_MASK;
         squash_d = 1'b0;
      end else if (w_issue) begin
         inflight_pc_d = pc_q;
         pc_d          = pc_q + INST_BYTES;
         inflight_d    = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q          <= c_RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         squash_q      <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         squash_q      <= squash_d;
      end
   end

   fetch_queue u_queue (
      .clock       (clock),
      .reset       (reset),
      .clear_i     (redirect),
      .push_i      (w_push),
      .push_inst_i (imem_data),
      .push_pc_i   (inflight_pc_q),
      .pop_i       (w_pop),
      .head_inst_o (inst),
      .head_pc_o   (inst_pc),
      .count_o     (w_count)
   );

   assign imem_addr = pc_q;
   assign imem_rd   = w_issue;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage. A transaction-level
//                model (queue of {inst, pc}, one outstanding read, next PC)
//                predicts the handshake outputs and read requests each cycle.
//                A second instance with RESET_PC=16'hFFFC covers PC wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        inst_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;

   logic [15:0] imem_addr, imem_data, inst, inst_pc;
   logic        imem_rd, inst_valid;
   logic [15:0] imem_addr_w, imem_data_w, inst_w, inst_pc_w;
   logic        imem_rd_w, inst_valid_w;

   always #5 clock = ~clock;

   fetch_stage dut (
      .clock(clock), .reset(reset),
      .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
      .inst_ready(inst_ready)
   );

   fetch_stage #(.RESET_PC(16'hFFFC), .BUF_DEPTH(2)) dut_w (
      .clock(clock), .reset(reset),
      .imem_addr(imem_addr_w), .imem_rd(imem_rd_w), .imem_data(imem_data_w),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .inst(inst_w), .inst_pc(inst_pc_w), .inst_valid(inst_valid_w),
      .inst_ready(inst_ready)
   );

   // Memory image: 16'h4008 at 0x0000, otherwise the word index.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return (a == 16'h0000) ? 16'h4008 : {1'b0, a[15:1]};
   endfunction

   initial imem_data   = 16'h0000;
   initial imem_data_w = 16'h0000;
   always @(posedge clock) if (imem_rd)   imem_data   <= mem_word(imem_addr);
   always @(posedge clock) if (imem_rd_w) imem_data_w <= mem_word(imem_addr_w);

   // ---------------- reference model ----------------
   typedef struct {
      logic [15:0] inst;
      logic [15:0] pc;
   } ent_t;

   ent_t        mq[$];
   logic [15:0] m_pc  = 16'h0000;
   logic [15:0] m_ipc = 16'h0000;
   bit          m_infl = 1'b0;
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h required %h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc   = 16'h0000;
      m_infl = 1'b0;
      cyc    = 0;
   endtask

   // One clock cycle: drive inputs, check outputs against the model,
   // then advance the model with the same inputs at the rising edge.
   task automatic step(input logic rst, input logic rdy, input logic redir,
                       input logic [15:0] rpc);
      bit   e_valid = 1'b0;
      bit   e_pop   = 1'b0;
      bit   e_rd    = 1'b0;
      int   occ;
      ent_t e;
      reset       = rst;
      inst_ready  = rdy;
      redirect    = redir;
      redirect_pc = rpc;
      #1;
      if (!rst) begin
         e_valid = (mq.size() != 0);
         e_pop   = e_valid && rdy;
         occ     = mq.size() + int'(m_infl);
         e_rd    = !redir && ((occ < 2) || ((occ == 2) && e_pop));
         chk("inst_valid", {15'b0, inst_valid}, {15'b0, e_valid});
         if (e_valid) begin
            chk("inst", inst, mq[0].inst);
            chk("inst_pc", inst_pc, mq[0].pc);
         end
         chk("imem_rd", {15'b0, imem_rd}, {15'b0, e_rd});
         if (e_rd) chk("imem_addr", imem_addr, m_pc);
      end
      @(posedge clock);
      if (rst) begin
         model_reset();
      end else begin
         if (e_pop) void'(mq.pop_front());
         if (redir) begin
            mq.delete();
            m_pc   = rpc & 16'hFFFE;
            m_infl = 1'b0;
         end else begin
            if (m_infl) begin
               e.inst = mem_word(m_ipc);
               e.pc   = m_ipc;
               mq.push_back(e);
            end
            if (e_rd) begin
               m_ipc  = m_pc;
               m_pc   = m_pc + 16'd2;
               m_infl = 1'b1;
            end else begin
               m_infl = 1'b0;
            end
         end
         cyc++;
      end
      @(negedge clock);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] wpc;
      int          hold;

      // Reset, then reset values of both instances.
      step(1'b1, 1'b1, 1'b0, 16'h0000);
      step(1'b1, 1'b1, 1'b0, 16'h0000);
      reset = 1'b0;
      #1;
      chk("rst_inst_valid", {15'b0, inst_valid}, 16'h0000);
      chk("rst_inst", inst, 16'h0000);
      chk("rst_inst_pc", inst_pc, 16'h0000);
      chk("rst_imem_addr", imem_addr, 16'h0000);
      chk("rst_imem_addr_w", imem_addr_w, 16'hFFFC);

      // Streaming at one instruction per cycle; wrap instance alongside.
      for (int i = 0; i < 10; i++) begin
         if (i >= 2 && i <= 4) begin
            wpc = 16'hFFFC + 16'(2 * (i - 2));
            chk("wrap_valid", {15'b0, inst_valid_w}, 16'h0001);
            chk("wrap_pc", inst_pc_w, wpc);
            chk("wrap_inst", inst_w, mem_word(wpc));
         end
         step(1'b0, 1'b1, 1'b0, 16'h0000);
      end

      // Back-pressure for 5 cycles from cycle 2, then a redirect to 0x0101.
      step(1'b1, 1'b1, 1'b0, 16'h0000);
      for (int i = 0; i < 13; i++)
         step(1'b0, (i < 2 || i > 6), 1'b0, 16'h0000);
      step(1'b0, 1'b1, 1'b1, 16'h0101);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);

      // Random ready with single and held redirects.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            hold = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++)
               step(1'b0, 1'($urandom_range(0, 1)), 1'b1,
                    (h == hold - 1) ? 16'h0040 : 16'($urandom));
         end else begin
            step(1'b0, ($urandom_range(0, 3) != 0), 1'b0, 16'($urandom));
         end
      end

      // Fill the queue, then reset together with a redirect.
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 16'h0000);
      step(1'b0, 1'b1, 1'b0, 16'h0000);
      step(1'b1, 1'b0, 1'b1, 16'h1234);
      reset = 1'b0;
      #1;
      chk("post_rst_valid", {15'b0, inst_valid}, 16'h0000);
      chk("post_rst_addr", imem_addr, 16'h0000);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_fetch_stage
`default_nettype wire
